// File: rtl/noc_node_if.sv
// Network-on-chip node interface: a TX FIFO packs PE words into flits for the
// switch, and an RX buffer keeps only flits addressed to this node for the PE.
module noc_node_if #(
  parameter int NodeId  = 0,
  parameter int TxDepth = 4,
  parameter int RxDepth = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [23:0] i_pe_data,
  input  logic [7:0]  i_pe_dest,
  input  logic        i_pe_valid,
  output logic        o_pe_ready,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  input  logic        i_data_ready,
  input  logic [31:0] i_data,
  input  logic        i_data_valid,
  output logic        o_data_ready,
  output logic [23:0] o_pe_rx_data,
  output logic        o_pe_rx_valid,
  input  logic        i_pe_rx_ready,
  output logic [15:0] o_misroute_cnt,
  output logic [15:0] o_tx_cnt
);

  localparam int TxAw = (TxDepth > 1) ? $clog2(TxDepth) : 1;
  localparam int RxAw = (RxDepth > 1) ? $clog2(RxDepth) : 1;
  localparam int TxCw = $clog2(TxDepth + 1);
  localparam int RxCw = $clog2(RxDepth + 1);
  localparam logic [TxCw-1:0] TxFull   = TxCw'(TxDepth);
  localparam logic [RxCw-1:0] RxFull   = RxCw'(RxDepth);
  localparam logic [7:0]      NodeAddr = 8'(NodeId);

  // ---------------- TX path ----------------
  logic [31:0]     tx_mem [TxDepth];
  logic [TxAw-1:0] tx_wr_ptr_reg, tx_rd_ptr_reg;
  logic [TxCw-1:0] tx_count_reg, tx_count_next;
  logic            tx_push, tx_pop;

  // Ready/valid come only from the occupancy register, never from the peer's ready.
  assign o_pe_ready   = (tx_count_reg != TxFull);
  assign o_data_valid = (tx_count_reg != '0);
  assign o_data       = tx_mem[tx_rd_ptr_reg];
  assign tx_push      = i_pe_valid & o_pe_ready;
  assign tx_pop       = o_data_valid & i_data_ready;

  always_ff @(posedge i_clk) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr_reg] <= {i_pe_dest, i_pe_data};
    end
  end

  always_comb begin
    tx_count_next = tx_count_reg;
    if (tx_push && !tx_pop) begin
      tx_count_next = tx_count_reg + TxCw'(1);
    end else if (!tx_push && tx_pop) begin
      tx_count_next = tx_count_reg - TxCw'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_wr_ptr_reg <= '0;
      tx_rd_ptr_reg <= '0;
      tx_count_reg  <= '0;
    end else begin
      tx_count_reg <= tx_count_next;
      if (tx_push) begin
        tx_wr_ptr_reg <= tx_wr_ptr_reg + TxAw'(1);
      end
      if (tx_pop) begin
        tx_rd_ptr_reg <= tx_rd_ptr_reg + TxAw'(1);
      end
    end
  end

  // ---------------- RX path ----------------
  logic [23:0]     rx_mem [RxDepth];
  logic [RxAw-1:0] rx_wr_ptr_reg, rx_rd_ptr_reg;
  logic [RxCw-1:0] rx_count_reg, rx_count_next;
  logic            rx_accept, rx_match, rx_push, rx_pop, rx_misroute;

  assign o_data_ready  = (rx_count_reg != RxFull);
  assign o_pe_rx_valid = (rx_count_reg != '0);
  assign o_pe_rx_data  = rx_mem[rx_rd_ptr_reg];
  assign rx_accept     = i_data_valid & o_data_ready;
  assign rx_match      = (i_data[31:24] == NodeAddr);
  assign rx_push       = rx_accept & rx_match;
  assign rx_misroute   = rx_accept & ~rx_match;
  assign rx_pop        = o_pe_rx_valid & i_pe_rx_ready;

  always_ff @(posedge i_clk) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr_reg] <= i_data[23:0];
    end
  end

  always_comb begin
    rx_count_next = rx_count_reg;
    if (rx_push && !rx_pop) begin
      rx_count_next = rx_count_reg + RxCw'(1);
    end else if (!rx_push && rx_pop) begin
      rx_count_next = rx_count_reg - RxCw'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_wr_ptr_reg <= '0;
      rx_rd_ptr_reg <= '0;
      rx_count_reg  <= '0;
    end else begin
      rx_count_reg <= rx_count_next;
      if (rx_push) begin
        rx_wr_ptr_reg <= rx_wr_ptr_reg + RxAw'(1);
      end
      if (rx_pop) begin
        rx_rd_ptr_reg <= rx_rd_ptr_reg + RxAw'(1);
      end
    end
  end

  // ---------------- statistics (saturating) ----------------
  logic [15:0] misroute_cnt_reg, tx_cnt_reg;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      misroute_cnt_reg <= '0;
      tx_cnt_reg       <= '0;
    end else begin
      if (rx_misroute && misroute_cnt_reg != 16'hFFFF) begin
        misroute_cnt_reg <= misroute_cnt_reg + 16'd1;
      end
      if (tx_pop && tx_cnt_reg != 16'hFFFF) begin
        tx_cnt_reg <= tx_cnt_reg + 16'd1;
      end
    end
  end

  assign o_misroute_cnt = misroute_cnt_reg;
  assign o_tx_cnt       = tx_cnt_reg;

endmodule

// File: tb/tb_noc_node_if.sv
// Bench for noc_node_if (NodeId=5): table of TX vectors, hand-written corner
// sequences, and random traffic checked against a queue-based reference model.
module tb_noc_node_if;

  localparam int TXD = 4;
  localparam int RXD = 2;
  localparam logic [7:0] ME = 8'h05;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [23:0] i_pe_data = '0;
  logic [7:0]  i_pe_dest = '0;
  logic        i_pe_valid = 1'b0;
  logic        o_pe_ready;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        i_data_ready = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_data_valid = 1'b0;
  logic        o_data_ready;
  logic [23:0] o_pe_rx_data;
  logic        o_pe_rx_valid;
  logic        i_pe_rx_ready = 1'b0;
  logic [15:0] o_misroute_cnt;
  logic [15:0] o_tx_cnt;

  noc_node_if #(.NodeId(5), .TxDepth(TXD), .RxDepth(RXD)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_pe_data(i_pe_data), .i_pe_dest(i_pe_dest), .i_pe_valid(i_pe_valid),
    .o_pe_ready(o_pe_ready), .o_data(o_data), .o_data_valid(o_data_valid),
    .i_data_ready(i_data_ready), .i_data(i_data), .i_data_valid(i_data_valid),
    .o_data_ready(o_data_ready), .o_pe_rx_data(o_pe_rx_data),
    .o_pe_rx_valid(o_pe_rx_valid), .i_pe_rx_ready(i_pe_rx_ready),
    .o_misroute_cnt(o_misroute_cnt), .o_tx_cnt(o_tx_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b1;

  // Reference model: plain queues and saturating counters.
  logic [31:0] tx_q[$];
  logic [23:0] rx_q[$];
  int          tx_cnt_m = 0;
  int          mis_cnt_m = 0;
  logic [23:0] dut_rx_log[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_reset();
    tx_q.delete();
    rx_q.delete();
    tx_cnt_m = 0;
    mis_cnt_m = 0;
  endtask

  task automatic compare_all();
    check("pe_ready", 32'(o_pe_ready), 32'(tx_q.size() < TXD));
    check("data_valid", 32'(o_data_valid), 32'(tx_q.size() > 0));
    if (tx_q.size() > 0) check("data", o_data, tx_q[0]);
    check("data_ready", 32'(o_data_ready), 32'(rx_q.size() < RXD));
    check("pe_rx_valid", 32'(o_pe_rx_valid), 32'(rx_q.size() > 0));
    if (rx_q.size() > 0) check("pe_rx_data", 32'(o_pe_rx_data), 32'(rx_q[0]));
    check("tx_cnt", 32'(o_tx_cnt), 32'(tx_cnt_m));
    check("misroute_cnt", 32'(o_misroute_cnt), 32'(mis_cnt_m));
  endtask

  // One clock: decide transfers from the model's pre-edge state, advance, compare.
  task automatic cycle();
    bit tx_push, tx_pop, rx_acc, rx_pop;
    logic [31:0] flit;
    tx_push = i_pe_valid && (tx_q.size() < TXD);
    tx_pop  = (tx_q.size() > 0) && i_data_ready;
    rx_acc  = i_data_valid && (rx_q.size() < RXD);
    rx_pop  = (rx_q.size() > 0) && i_pe_rx_ready;
    flit    = {i_pe_dest, i_pe_data};
    if (o_pe_rx_valid && i_pe_rx_ready) dut_rx_log.push_back(o_pe_rx_data);
    if (rx_acc) begin
      if (i_data[31:24] == ME) begin
        if (rx_pop) void'(rx_q.pop_front());
        rx_q.push_back(i_data[23:0]);
      end else begin
        if (rx_pop) void'(rx_q.pop_front());
        if (mis_cnt_m < 65535) mis_cnt_m++;
      end
    end else if (rx_pop) void'(rx_q.pop_front());
    if (tx_pop) begin
      void'(tx_q.pop_front());
      if (tx_cnt_m < 65535) tx_cnt_m++;
    end
    if (tx_push) tx_q.push_back(flit);
    @(posedge i_clk);
    #1;
    if (chk_en) compare_all();
  endtask

  task automatic idle_inputs();
    i_pe_valid = 1'b0;
    i_data_valid = 1'b0;
    i_pe_dest = '0;
    i_pe_data = '0;
    i_data = '0;
  endtask

  task automatic sync_reset();
    i_reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge i_clk);
    #1;
    model_reset();
    i_reset_n = 1'b1;
  endtask

  typedef struct {
    logic        pe_valid;
    logic [7:0]  dest;
    logic [23:0] pdata;
    logic        dready;
    logic        e_pe_ready;
    logic        e_dvalid;
    logic [31:0] e_data;
    logic [15:0] e_txcnt;
  } vec_t;

  vec_t vt[13];

  initial begin
    vt[0]  = '{1'b1, 8'h03, 24'h00ABCD, 1'b1, 1'b1, 1'b1, 32'h0300ABCD, 16'd0};
    vt[1]  = '{1'b0, 8'h00, 24'h000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 16'd1};
    vt[2]  = '{1'b1, 8'h20, 24'h000001, 1'b0, 1'b1, 1'b1, 32'h20000001, 16'd1};
    vt[3]  = '{1'b1, 8'h20, 24'h000002, 1'b0, 1'b1, 1'b1, 32'h20000001, 16'd1};
    vt[4]  = '{1'b1, 8'h20, 24'h000003, 1'b0, 1'b1, 1'b1, 32'h20000001, 16'd1};
    vt[5]  = '{1'b1, 8'h20, 24'h000004, 1'b0, 1'b0, 1'b1, 32'h20000001, 16'd1};
    vt[6]  = '{1'b1, 8'h20, 24'h000005, 1'b0, 1'b0, 1'b1, 32'h20000001, 16'd1};
    vt[7]  = '{1'b0, 8'h00, 24'h000000, 1'b1, 1'b1, 1'b1, 32'h20000002, 16'd2};
    vt[8]  = '{1'b0, 8'h00, 24'h000000, 1'b1, 1'b1, 1'b1, 32'h20000003, 16'd3};
    vt[9]  = '{1'b0, 8'h00, 24'h000000, 1'b1, 1'b1, 1'b1, 32'h20000004, 16'd4};
    vt[10] = '{1'b0, 8'h00, 24'h000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 16'd5};
    vt[11] = '{1'b1, 8'h05, 24'hFFFFFF, 1'b0, 1'b1, 1'b1, 32'h05FFFFFF, 16'd5};
    vt[12] = '{1'b0, 8'h00, 24'h000000, 1'b1, 1'b1, 1'b0, 32'h00000000, 16'd6};

    // Reset state
    i_pe_rx_ready = 1'b1;
    sync_reset();
    check("rst_pe_ready", 32'(o_pe_ready), 32'd1);
    check("rst_data_valid", 32'(o_data_valid), 32'd0);
    check("rst_data_ready", 32'(o_data_ready), 32'd1);
    check("rst_pe_rx_valid", 32'(o_pe_rx_valid), 32'd0);
    check("rst_tx_cnt", 32'(o_tx_cnt), 32'd0);
    check("rst_misroute", 32'(o_misroute_cnt), 32'd0);

    // TX table: single send, back-pressure fill, drain, own-dest passthrough
    for (int i = 0; i < 13; i++) begin
      i_pe_valid   = vt[i].pe_valid;
      i_pe_dest    = vt[i].dest;
      i_pe_data    = vt[i].pdata;
      i_data_ready = vt[i].dready;
      cycle();
      check($sformatf("vec%0d_pe_ready", i), 32'(o_pe_ready), 32'(vt[i].e_pe_ready));
      check($sformatf("vec%0d_data_valid", i), 32'(o_data_valid), 32'(vt[i].e_dvalid));
      if (vt[i].e_dvalid) check($sformatf("vec%0d_data", i), o_data, vt[i].e_data);
      check($sformatf("vec%0d_tx_cnt", i), 32'(o_tx_cnt), 32'(vt[i].e_txcnt));
    end
    idle_inputs();

    // RX: good flit delivered once, misrouted flit dropped
    dut_rx_log.delete();
    i_pe_rx_ready = 1'b1;
    i_data_valid = 1'b1;
    i_data = 32'h05123456;
    cycle();
    check("rx_first_valid", 32'(o_pe_rx_valid), 32'd1);
    check("rx_first_data", 32'(o_pe_rx_data), 32'h00123456);
    i_data = 32'h07000001;
    cycle();
    i_data_valid = 1'b0;
    repeat (3) cycle();
    check("misroute_one", 32'(o_misroute_cnt), 32'd1);
    check("rx_deliver_count", 32'(dut_rx_log.size()), 32'd1);
    if (dut_rx_log.size() > 0) check("rx_deliver_data", 32'(dut_rx_log[0]), 32'h00123456);

    // RX back-pressure: third flit waits until the PE drains
    dut_rx_log.delete();
    i_pe_rx_ready = 1'b0;
    i_data_valid = 1'b1;
    i_data = 32'h050000A1;
    cycle();
    i_data = 32'h050000A2;
    cycle();
    check("rx_full_ready", 32'(o_data_ready), 32'd0);
    i_data = 32'h050000A3;
    cycle();
    check("rx_still_full", 32'(o_data_ready), 32'd0);
    i_pe_rx_ready = 1'b1;
    cycle();
    cycle();
    i_data_valid = 1'b0;
    repeat (4) cycle();
    check("rx_bp_count", 32'(dut_rx_log.size()), 32'd3);
    for (int i = 0; i < 3 && i < dut_rx_log.size(); i++)
      check($sformatf("rx_bp_order%0d", i), 32'(dut_rx_log[i]), 32'hA1 + 32'(i));

    // Asynchronous reset with both FIFOs holding data
    i_data_ready = 1'b0;
    i_pe_rx_ready = 1'b0;
    i_pe_valid = 1'b1;
    i_pe_dest = 8'h09;
    i_pe_data = 24'h111111;
    i_data_valid = 1'b1;
    i_data = 32'h05222222;
    cycle();
    cycle();
    check("pre_rst_data_valid", 32'(o_data_valid), 32'd1);
    check("pre_rst_rx_valid", 32'(o_pe_rx_valid), 32'd1);
    #2;
    i_reset_n = 1'b0;
    #1;
    check("arst_pe_ready", 32'(o_pe_ready), 32'd1);
    check("arst_data_valid", 32'(o_data_valid), 32'd0);
    check("arst_data_ready", 32'(o_data_ready), 32'd1);
    check("arst_pe_rx_valid", 32'(o_pe_rx_valid), 32'd0);
    check("arst_tx_cnt", 32'(o_tx_cnt), 32'd0);
    check("arst_misroute", 32'(o_misroute_cnt), 32'd0);
    sync_reset();
    i_data_ready = 1'b1;
    i_pe_rx_ready = 1'b1;
    repeat (4) cycle();
    check("post_rst_no_tx", 32'(o_data_valid), 32'd0);
    check("post_rst_no_rx", 32'(o_pe_rx_valid), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      i_pe_valid    = 1'($urandom_range(0, 1));
      i_pe_dest     = ($urandom_range(0, 3) == 0) ? ME : 8'($urandom);
      i_pe_data     = 24'($urandom);
      i_data_ready  = ($urandom_range(0, 3) != 0);
      i_data_valid  = 1'($urandom_range(0, 1));
      i_data        = {(($urandom_range(0, 9) < 7) ? ME : 8'($urandom)), 24'($urandom)};
      i_pe_rx_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    idle_inputs();

    // Misroute counter saturation
    sync_reset();
    i_pe_rx_ready = 1'b1;
    i_data_valid = 1'b1;
    i_data = 32'h07000001;
    chk_en = 1'b0;
    for (int i = 0; i < 65535; i++) cycle();
    chk_en = 1'b1;
    check("misroute_at_max", 32'(o_misroute_cnt), 32'h0000FFFF);
    cycle();
    check("misroute_saturated", 32'(o_misroute_cnt), 32'h0000FFFF);
    check("misroute_no_delivery", 32'(o_pe_rx_valid), 32'd0);
    i_data_valid = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/noc_node_if.md
NOC_NODE_IF -- requirements
Module: noc_node_if

Interface
REQ-001 The block SHALL have parameter NodeId, default 0, meaning the 8-bit node address this interface owns.
REQ-002 The block SHALL have parameter TxDepth, default 4, meaning the TX FIFO depth in words (power of two, 2..16).
REQ-003 The block SHALL have parameter RxDepth, default 2, meaning the RX buffer depth in words (power of two, 2..16).
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port i_reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_pe_data, input, 24 bits: PE payload to send.
REQ-007 The block SHALL have port i_pe_dest, input, 8 bits: destination node of the payload.
REQ-008 The block SHALL have port i_pe_valid, input, 1 bit: PE TX word valid.
REQ-009 The block SHALL have port o_pe_ready, output, 1 bit: TX FIFO can accept.
REQ-010 The block SHALL have port o_data, output, 32 bits: flit to switch; [31:24]=dest, [23:0]=payload.
REQ-011 The block SHALL have port o_data_valid, output, 1 bit: flit valid toward switch.
REQ-012 The block SHALL have port i_data_ready, input, 1 bit: switch accepts flit.
REQ-013 The block SHALL have port i_data, input, 32 bits: flit from switch.
REQ-014 The block SHALL have port i_data_valid, input, 1 bit: flit from switch valid.
REQ-015 The block SHALL have port o_data_ready, output, 1 bit: RX buffer can accept.
REQ-016 The block SHALL have port o_pe_rx_data, output, 24 bits: delivered payload.
REQ-017 The block SHALL have port o_pe_rx_valid, output, 1 bit: delivered payload valid.
REQ-018 The block SHALL have port i_pe_rx_ready, input, 1 bit: PE accepts payload.
REQ-019 The block SHALL have port o_misroute_cnt, output, 16 bits: count of dropped flits not addressed to NodeId.
REQ-020 The block SHALL have port o_tx_cnt, output, 16 bits: count of flits accepted by the switch.

Function
REQ-021 All handshakes SHALL be valid/ready; a transfer occurs on a rising edge with valid and ready both high; valid, once high, is not required to be held by this block's sources, but this block SHALL hold o_data_valid/o_data and o_pe_rx_valid/o_pe_rx_data stable until accepted.
REQ-022 TX FIFO: an accepted PE word SHALL be stored as {i_pe_dest, i_pe_data}; FIFO order preserved; read/write pointers wrap modulo TxDepth; occupancy counter 0..TxDepth.
REQ-023 o_pe_ready SHALL be high iff TX occupancy < TxDepth, registered-state only (no combinational path from i_data_ready).
REQ-024 o_data_valid SHALL be high iff TX occupancy > 0; o_data SHALL be the head entry; latency PE accept -> o_data_valid = 1 cycle; no bypass.
REQ-025 Simultaneous TX push and pop SHALL leave occupancy unchanged; when full, push is blocked even if a pop occurs the same cycle.
REQ-026 The block SHALL NOT inspect or alter the dest field on TX; dest == NodeId SHALL be sent unchanged.
REQ-027 RX: o_data_ready SHALL be high iff RX occupancy < RxDepth, registered-state only.
REQ-028 An accepted flit with i_data[31:24] == NodeId SHALL be written to the RX buffer as i_data[23:0]; any other accepted flit SHALL be discarded and o_misroute_cnt incremented by 1.
REQ-029 o_pe_rx_valid SHALL be high iff RX occupancy > 0; latency switch accept -> o_pe_rx_valid = 1 cycle; simultaneous push/pop as REQ-025.
REQ-030 o_misroute_cnt and o_tx_cnt SHALL saturate at 16'hFFFF and never wrap; o_tx_cnt increments on each o_data_valid & i_data_ready cycle.

Reset
REQ-031 While i_reset_n is low (asserted asynchronously, released synchronously to i_clk by the system), both FIFOs SHALL be emptied, pointers and counters zeroed, o_pe_ready and o_data_ready high, o_data_valid and o_pe_rx_valid low, o_misroute_cnt and o_tx_cnt 0.
REQ-032 Reset mid-transfer SHALL discard all buffered words; no flit is emitted or delivered after reset releases until new input arrives.

Verification
REQ-033 NodeId=5; push dest 3, payload 0x00ABCD with i_data_ready=1 -> next cycle o_data=0x0300ABCD, o_data_valid=1; o_tx_cnt=1 after handshake.
REQ-034 i_data_ready=0; push 5 words -> first 4 accepted, o_pe_ready=0 after the 4th; release ready -> 4 flits in order, then o_data_valid=0.
REQ-035 Inject i_data=0x05123456 then 0x07000001 -> o_pe_rx_data=0x123456 delivered once; o_misroute_cnt=1; 0x000001 never delivered.
REQ-036 i_pe_rx_ready=0, inject 3 flits to NodeId -> o_data_ready=0 after 2; release -> 3 payloads in order.
REQ-037 Preload o_misroute_cnt to 0xFFFF via 65535 misrouted flits, inject one more -> stays 0xFFFF.
REQ-038 Assert i_reset_n=0 mid-cycle with both FIFOs non-empty -> outputs take REQ-031 values immediately, without a clock edge.
